// File: rtl/cpu_ctrl_if.sv
// Control bundle between the SRM controller (master) and the datapath/memory side (slave).
interface cpu_ctrl_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic [2:0] nsel;
  logic       write;
  logic       load_pc, reset_pc, load_ir, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       halted;

  modport master (
    input  opcode, op,
    output loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
           load_pc, reset_pc, load_ir, load_addr, addr_sel, mem_cmd, halted
  );
  modport slave (
    output opcode, op,
    input  loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
           load_pc, reset_pc, load_ir, load_addr, addr_sel, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Moore control FSM for the Simple RISC Machine: fetch, PC update, ALU ops, LDR/STR with wait states.
// Optional HALT state for 111/xx is enabled by defining CPU_FSM_HALT_EN.
module cpu_ctrl_fsm #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = $clog2(MEM_WAIT+1)
) (
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.master ctrl
);
  localparam logic [4:0] S_RST    = 5'd0,  S_IF1    = 5'd1,  S_IF2   = 5'd2,  S_UPDPC = 5'd3,
                         S_DECODE = 5'd4,  S_WIMM   = 5'd5,  S_GETA  = 5'd6,  S_GETB  = 5'd7,
                         S_EXECA  = 5'd8,  S_EXECZ  = 5'd9,  S_WREG  = 5'd10, S_CMPX  = 5'd11,
                         S_ADDR   = 5'd12, S_LDADDR = 5'd13, S_MRD   = 5'd14, S_LDWB  = 5'd15,
                         S_GETR   = 5'd16, S_SPASS  = 5'd17, S_MWR   = 5'd18, S_HALT  = 5'd19;

  // Instruction class captured in DECODE so later states never look at the IR again.
  localparam logic [2:0] K_ALU = 3'd0, K_UN = 3'd1, K_CMP = 3'd2, K_LDR = 3'd3, K_STR = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT-1);

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       kind_q, kind_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      kind_q  <= K_ALU;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    kind_d  = kind_q;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    if (cnt_q == CNT_LAST) state_d = S_IF2; else cnt_d = cnt_q + CNT_W'(1);
      S_IF2:    state_d = S_UPDPC;
      S_UPDPC:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_IF1;
        casez ({ctrl.opcode, ctrl.op})
          5'b110_10: state_d = S_WIMM;
          5'b110_00: begin state_d = S_GETB; kind_d = K_UN;  end
          5'b101_00,
          5'b101_10: begin state_d = S_GETA; kind_d = K_ALU; end
          5'b101_01: begin state_d = S_GETA; kind_d = K_CMP; end
          5'b101_11: begin state_d = S_GETB; kind_d = K_UN;  end
          5'b011_00: begin state_d = S_GETA; kind_d = K_LDR; end
          5'b100_00: begin state_d = S_GETA; kind_d = K_STR; end
`ifdef CPU_FSM_HALT_EN
          5'b111_??: state_d = S_HALT;
`endif
          default:   state_d = S_IF1;
        endcase
      end
      S_WIMM:   state_d = S_IF1;
      S_GETA:   state_d = (kind_q == K_LDR || kind_q == K_STR) ? S_ADDR : S_GETB;
      S_GETB:   state_d = (kind_q == K_CMP) ? S_CMPX : (kind_q == K_UN) ? S_EXECZ : S_EXECA;
      S_EXECA,
      S_EXECZ:  state_d = S_WREG;
      S_WREG:   state_d = S_IF1;
      S_CMPX:   state_d = S_IF1;
      S_ADDR:   state_d = S_LDADDR;
      S_LDADDR: state_d = (kind_q == K_STR) ? S_GETR : S_MRD;
      S_MRD:    if (cnt_q == CNT_LAST) state_d = S_LDWB; else cnt_d = cnt_q + CNT_W'(1);
      S_LDWB:   state_d = S_IF1;
      S_GETR:   state_d = S_SPASS;
      S_SPASS:  state_d = S_MWR;
      S_MWR:    if (cnt_q == CNT_LAST) state_d = S_IF1; else cnt_d = cnt_q + CNT_W'(1);
`ifdef CPU_FSM_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_RST;
    endcase
  end

  always_comb begin
    ctrl.loada = 1'b0; ctrl.loadb = 1'b0; ctrl.loadc = 1'b0; ctrl.loads = 1'b0;
    ctrl.asel = 1'b0; ctrl.bsel = 1'b0; ctrl.vsel = 2'b00; ctrl.nsel = 3'b000;
    ctrl.write = 1'b0; ctrl.load_pc = 1'b0; ctrl.reset_pc = 1'b0; ctrl.load_ir = 1'b0;
    ctrl.load_addr = 1'b0; ctrl.addr_sel = 1'b0; ctrl.mem_cmd = 2'b00;
    case (state_q)
      S_RST:    begin ctrl.reset_pc = 1'b1; ctrl.load_pc = 1'b1; end
      S_IF1:    begin ctrl.addr_sel = 1'b1; ctrl.mem_cmd = 2'b01; end
      S_IF2:    begin ctrl.addr_sel = 1'b1; ctrl.mem_cmd = 2'b01; ctrl.load_ir = 1'b1; end
      S_UPDPC:  ctrl.load_pc = 1'b1;
      S_WIMM:   begin ctrl.nsel = 3'b100; ctrl.vsel = 2'b01; ctrl.write = 1'b1; end
      S_GETA:   begin ctrl.loada = 1'b1; ctrl.nsel = 3'b100; end
      S_GETB:   begin ctrl.loadb = 1'b1; ctrl.nsel = 3'b001; end
      S_EXECA:  ctrl.loadc = 1'b1;
      S_EXECZ:  begin ctrl.loadc = 1'b1; ctrl.asel = 1'b1; end
      S_WREG:   begin ctrl.nsel = 3'b010; ctrl.write = 1'b1; end
      S_CMPX:   ctrl.loads = 1'b1;
      S_ADDR:   begin ctrl.bsel = 1'b1; ctrl.loadc = 1'b1; end
      S_LDADDR: ctrl.load_addr = 1'b1;
      S_MRD:    ctrl.mem_cmd = 2'b01;
      S_LDWB:   begin ctrl.mem_cmd = 2'b01; ctrl.nsel = 3'b010; ctrl.vsel = 2'b10; ctrl.write = 1'b1; end
      S_GETR:   begin ctrl.loadb = 1'b1; ctrl.nsel = 3'b010; end
      S_SPASS:  begin ctrl.asel = 1'b1; ctrl.loadc = 1'b1; end
      S_MWR:    ctrl.mem_cmd = 2'b10;
      default:  ;
    endcase
  end

`ifdef CPU_FSM_HALT_EN
  assign ctrl.halted = (state_q == S_HALT);
`else
  assign ctrl.halted = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench: two controllers (MEM_WAIT=1 and 3); per-instruction cycle/strobe profiles from a table.
module tb_cpu_ctrl_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_ctrl_if if1 ();
  cpu_ctrl_if if3 ();
  cpu_ctrl_fsm #(.MEM_WAIT(1)) u1 (.clk(clk), .reset(reset), .ctrl(if1.master));
  cpu_ctrl_fsm #(.MEM_WAIT(3)) u3 (.clk(clk), .reset(reset), .ctrl(if3.master));

  typedef struct packed {
    logic loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic write, load_pc, reset_pc, load_ir, load_addr, addr_sel;
    logic [1:0] mem_cmd;
    logic halted;
  } obs_t;

  typedef struct {
    int         dsel;
    logic [2:0] opc;
    logic [1:0] op;
    int         cyc, wr, lds, ldc, asl, bsl, rd, wrc;
    logic [2:0] wn;
    logic [1:0] wv;
  } vec_t;

  obs_t o1, o3, s;
  int   dsel = 0;
  int   nchecks = 0, nerr = 0;

  assign o1 = '{if1.loada, if1.loadb, if1.loadc, if1.loads, if1.asel, if1.bsel, if1.vsel, if1.nsel,
                if1.write, if1.load_pc, if1.reset_pc, if1.load_ir, if1.load_addr, if1.addr_sel,
                if1.mem_cmd, if1.halted};
  assign o3 = '{if3.loada, if3.loadb, if3.loadc, if3.loads, if3.asel, if3.bsel, if3.vsel, if3.nsel,
                if3.write, if3.load_pc, if3.reset_pc, if3.load_ir, if3.load_addr, if3.addr_sel,
                if3.mem_cmd, if3.halted};
  assign s  = (dsel == 1) ? o3 : o1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs_rst();
    obs_t v = '0;
    v.reset_pc = 1'b1; v.load_pc = 1'b1;
    return v;
  endfunction

  function automatic obs_t obs_if1();
    obs_t v = '0;
    v.addr_sel = 1'b1; v.mem_cmd = 2'b01;
    return v;
  endfunction

  task automatic set_ir(input logic [2:0] opc, input logic [1:0] op);
    if1.opcode = opc; if1.op = op;
    if3.opcode = opc; if3.op = op;
  endtask

  // Leaves the bench at the negedge of the first IF1 cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'(s), 32'(obs_rst()));
    reset = 1'b0;
    @(negedge clk);
    chk("if1_outputs", 32'(s), 32'(obs_if1()));
  endtask

  task automatic run_instr(input vec_t v, input int idx);
    int cyc = 0, wr = 0, lds = 0, ldc = 0, asl = 0, bsl = 0, rd = 0, wrc = 0, bad = 0, hlt = 0;
    logic [2:0] wn = '0;
    logic [1:0] wv = '0;
    bit seen_ir = 0, done = 0;
    string tag;
    set_ir(v.opc, v.op);
    for (int k = 0; k < 64 && !done; k++) begin
      cyc++;
      if (s.write)         begin wr++; wn = s.nsel; wv = s.vsel; end
      if (s.loads)         lds++;
      if (s.loadc)         ldc++;
      if (s.asel)          asl++;
      if (s.bsel)          bsl++;
      if (s.mem_cmd == 2'b01) rd++;
      if (s.mem_cmd == 2'b10) begin wrc++; if (s.addr_sel) bad++; end
      if (s.mem_cmd == 2'b11 || (s.write && s.mem_cmd == 2'b10)) bad++;
      if (s.halted)        hlt++;
      if (s.load_ir)       seen_ir = 1;
      @(negedge clk);
      if (seen_ir && s.addr_sel && s.mem_cmd == 2'b01 && !s.load_ir) done = 1;
    end
    tag = $sformatf("v%0d_", idx);
    chk({tag, "done"},   32'(done), 32'd1);
    chk({tag, "cycles"}, 32'(cyc),  32'(v.cyc));
    chk({tag, "writes"}, 32'(wr),   32'(v.wr));
    chk({tag, "loads"},  32'(lds),  32'(v.lds));
    chk({tag, "loadc"},  32'(ldc),  32'(v.ldc));
    chk({tag, "asel"},   32'(asl),  32'(v.asl));
    chk({tag, "bsel"},   32'(bsl),  32'(v.bsl));
    chk({tag, "rd_cyc"}, 32'(rd),   32'(v.rd));
    chk({tag, "wr_cyc"}, 32'(wrc),  32'(v.wrc));
    chk({tag, "wnsel"},  32'(wn),   32'(v.wn));
    chk({tag, "wvsel"},  32'(wv),   32'(v.wv));
    chk({tag, "illegal"},32'(bad),  32'd0);
    chk({tag, "halted"}, 32'(hlt),  32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    int cur;
    bit found;
    int bad;
    set_ir(3'b000, 2'b00);
    //          dsel opc     op     cyc wr lds ldc asl bsl rd wrc wn      wv
    tbl.push_back('{0, 3'b110, 2'b10,  5, 1, 0, 0, 0, 0, 2, 0, 3'b100, 2'b01}); // MOV imm
    tbl.push_back('{0, 3'b110, 2'b00,  7, 1, 0, 1, 1, 0, 2, 0, 3'b010, 2'b00}); // MOV reg
    tbl.push_back('{0, 3'b101, 2'b00,  8, 1, 0, 1, 0, 0, 2, 0, 3'b010, 2'b00}); // ADD
    tbl.push_back('{0, 3'b101, 2'b10,  8, 1, 0, 1, 0, 0, 2, 0, 3'b010, 2'b00}); // AND
    tbl.push_back('{0, 3'b101, 2'b01,  7, 0, 1, 0, 0, 0, 2, 0, 3'b000, 2'b00}); // CMP
    tbl.push_back('{0, 3'b101, 2'b11,  7, 1, 0, 1, 1, 0, 2, 0, 3'b010, 2'b00}); // MVN
    tbl.push_back('{0, 3'b100, 2'b00, 10, 0, 0, 2, 1, 1, 2, 1, 3'b000, 2'b00}); // STR
    tbl.push_back('{0, 3'b011, 2'b00,  9, 1, 0, 1, 0, 1, 4, 0, 3'b010, 2'b10}); // LDR
    tbl.push_back('{0, 3'b001, 2'b00,  4, 0, 0, 0, 0, 0, 2, 0, 3'b000, 2'b00}); // NOP
`ifndef CPU_FSM_HALT_EN
    tbl.push_back('{0, 3'b111, 2'b00,  4, 0, 0, 0, 0, 0, 2, 0, 3'b000, 2'b00}); // 111 as NOP
`endif
    tbl.push_back('{1, 3'b011, 2'b00, 13, 1, 0, 1, 0, 1, 8, 0, 3'b010, 2'b10}); // LDR, 3 waits
    tbl.push_back('{1, 3'b101, 2'b00, 10, 1, 0, 1, 0, 0, 4, 0, 3'b010, 2'b00}); // ADD, 3 waits

    dsel = 0; cur = 0;
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].dsel != cur) begin
        cur = tbl[i].dsel; dsel = cur;
        do_reset();
      end
      run_instr(tbl[i], i);
    end

    // Reset in the middle of a memory write.
    dsel = 0;
    do_reset();
    set_ir(3'b100, 2'b00);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (s.mem_cmd == 2'b10) found = 1;
    end
    chk("mwr_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mwr_reset_outputs", 32'(s), 32'(obs_rst()));
    reset = 1'b0;
    @(negedge clk);
    chk("mwr_reset_if1", 32'(s), 32'(obs_if1()));

`ifdef CPU_FSM_HALT_EN
    set_ir(3'b111, 2'b00);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (s.halted) found = 1;
    end
    chk("halt_reached", 32'(found), 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      obs_t h = '0;
      h.halted = 1'b1;
      if (s !== h) bad++;
      @(negedge clk);
    end
    chk("halt_held", 32'(bad), 32'd0);
    do_reset();
`else
    bad = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
